// File: rtl/seg_display_pkg.sv
// Shared types, active-low glyph constants and helpers for the seven-segment controller.
// Glyph constants carry bit 7 = 1 (dp off); callers overwrite bit 7 with the live dp.
package seg_display_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_0     = 8'hC0;
    localparam seg_t SEG_1     = 8'hF9;
    localparam seg_t SEG_2     = 8'hA4;
    localparam seg_t SEG_3     = 8'hB0;
    localparam seg_t SEG_4     = 8'h99;
    localparam seg_t SEG_5     = 8'h92;
    localparam seg_t SEG_6     = 8'h82;
    localparam seg_t SEG_7     = 8'hF8;
    localparam seg_t SEG_8     = 8'h80;
    localparam seg_t SEG_9     = 8'h90;
    localparam seg_t SEG_A     = 8'h88;
    localparam seg_t SEG_B     = 8'h83;
    localparam seg_t SEG_C     = 8'hC6;
    localparam seg_t SEG_D     = 8'hA1;
    localparam seg_t SEG_E     = 8'h86;
    localparam seg_t SEG_F     = 8'h8E;
    localparam seg_t SEG_DASH  = 8'hBF;
    localparam seg_t SEG_BLANK = 8'hFF;

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

    // Enough BCD digits to hold any 4*digits-bit binary value.
    function automatic int bcd_digits(input int digits);
        return digits + (digits + 3) / 4;
    endfunction

endpackage

// File: rtl/seg_bcd_conv.sv
// Double-dabble binary-to-BCD converter: W shift cycles, result held on done for one cycle.
// start is only honoured in IDLE; busy stays high from the cycle after start until commit.
module seg_bcd_conv
    import seg_display_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] value,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] bcd,
    output logic         ovf
);

    localparam int BD = bcd_digits(W / 4);
    localparam int BW = 4 * BD;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [BW-1:0] bcd_r;
    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;

    function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] cur, input logic bit_in);
        logic [BW-1:0] adj;
        adj = cur;
        for (int i = 0; i < BD; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[BW-2:0], bit_in};
    endfunction

    // The first shift happens on the start edge itself, so IDLE->DONE spans exactly W shifts.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd_r <= '0;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_r <= dd_step('0, value[W-1]);
                        sr    <= value << 1;
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_r <= dd_step(bcd_r, sr[W-1]);
                    sr    <= sr << 1;
                    if (cnt == CW'(W - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bcd = bcd_r[W-1:0];
    assign ovf = |bcd_r[BW-1:W];

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-bank multiplexed 7-seg controller; outputs registered one cycle behind the scan counters.
// Hex loads commit immediately; decimal loads commit after conversion, loads while busy are dropped.
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BANKS    = 2,
    parameter int PRESCALE = 50000
) (
    input  logic                        i_mclk,
    input  logic                        i_reset_n,
    input  logic [BANKS*4*DIGITS-1:0]   i_value,
    input  logic [BANKS-1:0]            i_load,
    input  logic [BANKS-1:0]            i_mode,
    input  logic [BANKS-1:0]            i_lzb,
    input  logic [BANKS*DIGITS-1:0]     i_dp,
    output logic [BANKS-1:0]            o_busy,
    output logic [BANKS*8-1:0]          o_seg,
    output logic [BANKS*DIGITS-1:0]     o_an
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(PRESCALE);
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]           presc;
    logic [SW-1:0]           scan;
    logic [W-1:0]            disp [BANKS];
    logic [W-1:0]            bcd  [BANKS];
    logic [BANKS-1:0]        disp_ovf, disp_lzb, pend_lzb;
    logic [BANKS-1:0]        start, hex_load, done, ovf;
    logic [BANKS*8-1:0]      seg_next;
    logic [BANKS*DIGITS-1:0] an_next;

    assign start    = i_load &  i_mode & ~o_busy;
    assign hex_load = i_load & ~i_mode & ~o_busy;

    for (genvar gb = 0; gb < BANKS; gb++) begin : g_bank
        seg_bcd_conv #(.W(W)) u_conv (
            .clk     (i_mclk),
            .reset_n (i_reset_n),
            .start   (start[gb]),
            .value   (i_value[gb*W +: W]),
            .busy    (o_busy[gb]),
            .done    (done[gb]),
            .bcd     (bcd[gb]),
            .ovf     (ovf[gb])
        );
    end

    // lzb for a decimal load is captured at the load but only takes effect with the result.
    always_ff @(posedge i_mclk) begin
        if (!i_reset_n) begin
            for (int b = 0; b < BANKS; b++) disp[b] <= '0;
            disp_ovf <= '0;
            disp_lzb <= '0;
            pend_lzb <= '0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                if (hex_load[b]) begin
                    disp[b]     <= i_value[b*W +: W];
                    disp_ovf[b] <= 1'b0;
                    disp_lzb[b] <= i_lzb[b];
                end
                if (start[b]) pend_lzb[b] <= i_lzb[b];
                if (done[b]) begin
                    disp[b]     <= bcd[b];
                    disp_ovf[b] <= ovf[b];
                    disp_lzb[b] <= pend_lzb[b];
                end
            end
        end
    end

    always_comb begin
        logic [3:0]    nib;
        logic [SW-1:0] msd;
        logic          dp;
        seg_t          glyph;
        seg_next = '1;
        an_next  = '1;
        for (int b = 0; b < BANKS; b++) begin
            nib = '0;
            msd = '0;
            dp  = 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                if (disp[b][4*k +: 4] != 4'h0) msd = SW'(k);
                if (SW'(k) == scan) begin
                    nib = disp[b][4*k +: 4];
                    dp  = i_dp[b*DIGITS + k];
                end
                if (presc != '0) an_next[b*DIGITS + k] = (SW'(k) != scan);
            end
            if (disp_ovf[b])                     glyph = SEG_DASH;
            else if (disp_lzb[b] && (scan > msd)) glyph = SEG_BLANK;
            else                                 glyph = hex_to_seg(nib);
            glyph[7] = ~dp;
            seg_next[b*8 +: 8] = glyph;
        end
    end

    always_ff @(posedge i_mclk) begin
        if (!i_reset_n) begin
            presc <= '0;
            scan  <= '0;
            o_seg <= '1;
            o_an  <= '1;
        end else begin
            if (presc == PW'(PRESCALE - 1)) begin
                presc <= '0;
                scan  <= (scan == SW'(DIGITS - 1)) ? '0 : scan + SW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
            o_seg <= seg_next;
            o_an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: directed scenarios plus random traffic against a cycle-level model.
module tb_seg_display_ctrl;

    localparam int D = 4;
    localparam int B = 2;
    localparam int P = 4;
    localparam int W = 16;

    logic            clk;
    logic            reset_n;
    logic [B*W-1:0]  value;
    logic [B-1:0]    load, mode, lzb, busy;
    logic [B*D-1:0]  dp, an;
    logic [B*8-1:0]  seg;

    int chk_cnt = 0;
    int pass_cnt = 0;

    // model state
    int m_val[B];
    bit m_dec[B];
    bit m_lzb[B];
    int busy_cnt[B];
    int pend_val[B];
    bit pend_lzb[B];
    int t;
    int sh_presc = -1;
    int sh_scan = -1;

    seg_display_ctrl #(.DIGITS(D), .BANKS(B), .PRESCALE(P)) dut (
        .i_mclk    (clk),
        .i_reset_n (reset_n),
        .i_value   (value),
        .i_load    (load),
        .i_mode    (mode),
        .i_lzb     (lzb),
        .i_dp      (dp),
        .o_busy    (busy),
        .o_seg     (seg),
        .o_an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] glyph7(input int n);
        case (n)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [7:0] exp_digit(input int b, input int k, input logic dpb);
        int base, pw, dig;
        logic [6:0] g;
        base = m_dec[b] ? 10 : 16;
        pw = 1;
        for (int i = 0; i < k; i++) pw = pw * base;
        dig = (m_val[b] / pw) % base;
        if (m_dec[b] && m_val[b] > 9999)          g = 7'h3F;
        else if (m_lzb[b] && k > 0 && m_val[b] < pw) g = 7'h7F;
        else                                      g = glyph7(dig);
        return {~dpb, g};
    endfunction

    task automatic model_reset();
        for (int b = 0; b < B; b++) begin
            m_val[b] = 0; m_dec[b] = 0; m_lzb[b] = 0; busy_cnt[b] = 0;
            pend_val[b] = 0; pend_lzb[b] = 0;
        end
        t = 0;
    endtask

    // One clock: predict outputs from pre-edge state and inputs, advance model, compare.
    task automatic step();
        logic [B*8-1:0] es;
        logic [B*D-1:0] ea;
        logic [B-1:0]   eb;
        int presc, scan;
        es = '1; ea = '1; eb = '0;
        if (!reset_n) begin
            model_reset();
            sh_presc = -1;
            sh_scan = -1;
        end else begin
            presc = t % P;
            scan = (t / P) % D;
            sh_presc = presc;
            sh_scan = scan;
            for (int b = 0; b < B; b++) begin
                es[b*8 +: 8] = exp_digit(b, scan, dp[b*D + scan]);
                ea[b*D +: D] = (presc == 0) ? 4'hF : ~(4'b0001 << scan);
            end
            for (int b = 0; b < B; b++) begin
                if (busy_cnt[b] > 0) begin
                    busy_cnt[b]--;
                    if (busy_cnt[b] == 0) begin
                        m_val[b] = pend_val[b]; m_dec[b] = 1; m_lzb[b] = pend_lzb[b];
                    end
                end else if (load[b]) begin
                    if (mode[b]) begin
                        busy_cnt[b] = W;
                        pend_val[b] = int'(value[b*W +: W]);
                        pend_lzb[b] = lzb[b];
                    end else begin
                        m_val[b] = int'(value[b*W +: W]); m_dec[b] = 0; m_lzb[b] = lzb[b];
                    end
                end
                eb[b] = (busy_cnt[b] > 0);
            end
            t++;
        end
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(ea));
        check("seg", 32'(seg), 32'(es));
        check("busy", 32'(busy), 32'(eb));
    endtask

    task automatic do_load(input int b, input int v, input bit md, input bit lz);
        value[b*W +: W] = v[W-1:0];
        mode[b] = md;
        lzb[b] = lz;
        load[b] = 1'b1;
        step();
        load = '0;
    endtask

    task automatic wait_digit(input int d);
        int n;
        bit found;
        n = 0;
        found = 0;
        while (!found && n < 40) begin
            step();
            n++;
            found = (sh_presc == 1 && sh_scan == d);
        end
        check("slot_found", 32'(found), 32'd1);
    endtask

    task automatic wait_idle(input int b);
        int n;
        n = 0;
        while (busy[b] && n < 40) begin
            step();
            n++;
        end
        check("idle_reached", 32'(busy[b]), 32'd0);
    endtask

    initial begin
        int nb, n, f0, f1;
        logic [3:0] a_exp;
        reset_n = 0; value = '0; load = '0; mode = '0; lzb = '0; dp = '0;
        model_reset();

        // reset and release
        repeat (3) step();
        check("rst_seg", 32'(seg), 32'hFFFF);
        reset_n = 1;
        step();
        check("rel_an", 32'(an), 32'hFF);
        step();
        check("first_an", 32'(an[3:0]), 32'hE);

        // hex load
        do_load(0, 16'h12AB, 0, 0);
        wait_digit(0);
        check("hex_d0_an", 32'(an[3:0]), 32'hE);
        check("hex_d0_seg", 32'(seg[7:0]), 32'h83);
        wait_digit(3);
        check("hex_d3_an", 32'(an[3:0]), 32'h7);
        check("hex_d3_seg", 32'(seg[7:0]), 32'hF9);
        n = 0;
        while (sh_presc != 0 && n < 8) begin step(); n++; end
        check("ghost_an", 32'(an), 32'hFF);

        // decimal load, busy length and old display held
        do_load(1, 1234, 1, 0);
        nb = 0; n = 0;
        while (busy[1] && n < 40) begin
            nb++;
            check("hold_old", 32'(seg[15:8]), 32'hC0);
            step();
            n++;
        end
        check("busy_len", 32'(nb), 32'd16);
        wait_digit(3);
        check("dec_d3", 32'(seg[15:8]), 32'hF9);
        wait_digit(0);
        check("dec_d0", 32'(seg[15:8]), 32'h99);

        // overflow, then lzb
        do_load(1, 12345, 1, 0);
        wait_idle(1);
        for (int d = 0; d < D; d++) begin
            wait_digit(d);
            check("ovf_dash", 32'(seg[15:8]), 32'hBF);
        end
        do_load(1, 7, 1, 1);
        wait_idle(1);
        wait_digit(0);
        check("lzb_d0", 32'(seg[15:8]), 32'hF8);
        for (int d = 1; d < D; d++) begin
            wait_digit(d);
            a_exp = ~(4'b0001 << d);
            check("lzb_blank", 32'(seg[15:8]), 32'hFF);
            check("lzb_an", 32'(an[7:4]), 32'(a_exp));
        end

        // load while busy ignored
        do_load(1, 99, 1, 0);
        repeat (3) step();
        do_load(1, 555, 1, 0);
        wait_idle(1);
        wait_digit(0);
        check("ign_d0", 32'(seg[15:8]), 32'h90);
        wait_digit(1);
        check("ign_d1", 32'(seg[15:8]), 32'h90);
        wait_digit(2);
        check("ign_d2", 32'(seg[15:8]), 32'hC0);

        // reset mid-conversion
        do_load(1, 4321, 1, 0);
        repeat (7) step();
        reset_n = 0;
        step();
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1;
        wait_digit(0);
        check("rst_zero_b1", 32'(seg[15:8]), 32'hC0);
        check("rst_zero_b0", 32'(seg[7:0]), 32'hC0);

        // simultaneous loads, then dp mask
        value = {16'd9999, 16'd42};
        mode = 2'b11; lzb = 2'b00; load = 2'b11;
        step();
        load = '0;
        n = 0; f0 = -1; f1 = -1;
        while (n < 40 && (f0 < 0 || f1 < 0)) begin
            step();
            n++;
            if (!busy[0] && f0 < 0) f0 = n;
            if (!busy[1] && f1 < 0) f1 = n;
        end
        check("same_fall", 32'(f0), 32'(f1));
        check("fall_at", 32'(f0), 32'd16);
        dp = 8'b0001_0010;
        for (int d = 0; d < D; d++) begin
            wait_digit(d);
            check("dp_b0", 32'(seg[7]), (d == 1) ? 32'd0 : 32'd1);
            check("dp_b1", 32'(seg[15]), (d == 0) ? 32'd0 : 32'd1);
        end

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < B; b++) begin
                load[b] = ($urandom_range(0, 7) == 0);
                mode[b] = $urandom_range(0, 1) == 1;
                lzb[b] = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 2) == 0) value[b*W +: W] = 16'($urandom_range(0, 120));
                else value[b*W +: W] = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) dp = 8'($urandom);
            reset_n = ($urandom_range(0, 199) != 0);
            step();
        end
        reset_n = 1;
        load = '0;
        repeat (20) step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Parametrised multi-bank, time-multiplexed seven-segment display controller for the processor_arm I/O shell. It generalises the fixed two-display D0/D1 outputs to BANKS banks of DIGITS digits. Each bank shows a binary value in hex or decimal, with leading-zero blanking and decimal points. Decimal conversion is sequential (double-dabble) with a load/busy handshake.

Parameters:
DIGITS, 4, digits per bank; value width W = 4*DIGITS.
BANKS, 2, independent display banks (channels).
PRESCALE, 50000, i_mclk cycles per digit slot; must be at least 2.

Ports:
i_mclk  in  1  system clock; all state updates on the rising edge.
i_reset_n  in  1  synchronous reset, active-low.
i_value  in  BANKS*W  per-bank binary value; bank b occupies [b*W +: W].
i_load  in  BANKS  per-bank load strobe, one cycle.
i_mode  in  BANKS  per-bank mode: 0 = hex, 1 = decimal; sampled with i_load.
i_lzb  in  BANKS  per-bank leading-zero blank enable; sampled with i_load.
i_dp  in  BANKS*DIGITS  per-bank decimal-point mask, 1 = lit; sampled live.
o_busy  out  BANKS  per-bank decimal conversion in progress.
o_seg  out  BANKS*8  per-bank segments, active-low; bit 7 = dp, bits [6:0] = {g,f,e,d,c,b,a}.
o_an  out  BANKS*DIGITS  per-bank anodes, active-low; bit k = digit k, digit 0 = least significant.

Behaviour:
- Reset (i_reset_n low at an edge):
  - o_seg all 1s, o_an all 1s, o_busy 0.
  - Prescaler 0, scan index 0.
  - Display registers: zero, hex mode, lzb off.
  - Reset mid-conversion aborts the conversion; no partial result is committed.
- Scan:
  - Prescaler counts 0..PRESCALE-1 and wraps; at terminal count the scan index advances 0..DIGITS-1 and wraps.
  - All banks share the prescaler and the scan index.
  - o_seg and o_an are registered, lagging the counters by one cycle.
  - During prescaler count 0 of each slot, all anodes are off (ghost blanking).
  - For the rest of the slot, only o_an bit for the current digit is 0.
  - Refresh period is DIGITS*PRESCALE cycles.
- Hex load (i_load[b]=1, i_mode[b]=0, o_busy[b]=0):
  - The bank's display register takes the value at the same edge.
  - The new value is visible from the next slot update.
  - o_busy[b] stays 0.
- Decimal load (i_mode[b]=1, o_busy[b]=0):
  - o_busy[b] rises on the next cycle.
  - The converter runs exactly W shift cycles; o_busy[b] falls on the cycle the result is committed.
  - Total latency from load to commit: W+1 cycles.
  - The old display is held throughout the conversion.
- i_load[b] while o_busy[b]=1 is ignored. There is no queueing and the current conversion is unaffected.
- Banks are fully independent. Simultaneous loads on different banks are all accepted.
- Decimal overflow: the internal BCD has BCD_DIGITS = DIGITS + (DIGITS+3)/4 digits. If any digit at or above position DIGITS is nonzero, every digit shows '-' and leading-zero blanking is suppressed.
- Leading-zero blanking: when lzb is latched on, digits above the most significant nonzero digit output segments 7'h7F. The dp bit still follows i_dp. Digit 0 is never blanked.
- Glyphs: 0-9 and A, b, C, d, E, F (hex), plus '-' (g only).

Decomposition:
- Package seg_display_pkg holds:
  - typedef seg_t (8 bits);
  - glyph constants SEG_0..SEG_F, SEG_DASH, SEG_BLANK;
  - function hex_to_seg;
  - function bcd_digits(DIGITS).
- Sub-module seg_bcd_conv (parameter W) is instantiated once per bank via generate. It is a double-dabble FSM with states IDLE, SHIFT, DONE; ports start, value, busy, done, bcd, ovf.
- Top level holds the prescaler, scan counter, per-bank display registers and output mux.

Test Plan (DIGITS=4, BANKS=2, PRESCALE=4):
1. Reset held 3 cycles, then released -> o_an=8'hFF, o_seg=16'hFFFF, o_busy=2'b00. The first anode goes low (o_an[3:0]=4'b1110) 2 cycles after release.
2. Hex load 16'h12AB on bank 0, lzb off, dp off -> slot 0: o_an[3:0]=4'b1110, o_seg[7:0]=8'h83 ('b'). Slot 3: o_an[3:0]=4'b0111, o_seg[7:0]=8'hF9 ('1'). Anodes are off on prescaler count 0 of each slot.
3. Decimal load 16'd1234 on bank 1 -> o_busy[1]=1 for 16 cycles, old value displayed meanwhile. Then digit 3 on bank 1 gives o_seg[15:8]=8'hF9, and digit 0 gives 8'h99 ('4').
4. Decimal load 16'd12345 -> overflow: every digit o_seg=8'hBF. Decimal load 16'd7 with lzb on -> digit 0 = 8'hF8; digits 1-3 = 8'hFF with anodes still scanned.
5. A second i_load on bank 1 four cycles after starting a conversion of 16'd99 -> ignored, and bank 1 shows 99. i_reset_n low at cycle 8 of a conversion -> o_busy=0, and the display shows blank-zero state.
6. Simultaneous decimal loads on both banks (16'd42, 16'd9999) -> both o_busy bits fall on the same cycle. i_dp=8'b0001_0010 -> bit 7 is 0 only on bank 0 digit 1 and bank 1 digit 0.
